// File: rtl/p_hit_feeder.sv
// ============================================================================
// Module   : p_hit_feeder
// Brief    : Pairs every ray popped from an upstream FWFT FIFO with every
//            triangle in a small local table. Drives the p_hit input FIFOs.
//            Optional macro P_HIT_FEEDER_STATS_EN adds issue/stall counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module p_hit_feeder #(
    parameter int D_BITS = 32,
    parameter int Q_BITS = 16,
    parameter int N_TRI  = 8,
    localparam int IDX_W = (N_TRI > 1) ? $clog2(N_TRI) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  tri_we,
    input  logic                  tri_clear,
    input  logic [3*D_BITS-1:0]   tri_normal_in,
    input  logic [3*D_BITS-1:0]   tri_v0_in,
    output logic                  tri_full,
    output logic                  busy,
    input  logic                  ray_empty,
    output logic                  ray_rd_en,
    input  logic [3*D_BITS-1:0]   ray_origin,
    input  logic [3*D_BITS-1:0]   ray_dir,
    input  logic [3:0]            in_full,
    output logic [3:0]            in_wr_en,
    output logic [3*D_BITS-1:0]   tri_normal,
    output logic [3*D_BITS-1:0]   v0,
    output logic [3*D_BITS-1:0]   origin,
    output logic [3*D_BITS-1:0]   dir,
    output logic [IDX_W-1:0]      tri_idx,
    output logic                  ray_last
`ifdef P_HIT_FEEDER_STATS_EN
    ,
    output logic [31:0]           issue_count,
    output logic [31:0]           stall_count
`endif
);

    // Q_BITS only documents the word format; data passes through untouched.
    localparam int W3    = 3 * D_BITS + 0 * Q_BITS;
    localparam int CNT_W = IDX_W + 1;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_tri_count;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [W3-1:0]      r_origin;
    logic [W3-1:0]      r_dir;
    logic [W3-1:0]      r_norm_hold;
    logic [W3-1:0]      r_v0_hold;
    logic [W3-1:0]      r_tab_norm [N_TRI];
    logic [W3-1:0]      r_tab_v0   [N_TRI];
    logic               w_issue;
    logic               w_last;
    logic               w_pop;
    logic               w_tri_full;
    logic               w_load;

    assign w_tri_full = (r_tri_count == CNT_W'(N_TRI));
    assign w_last     = ({1'b0, r_idx} == (r_tri_count - CNT_W'(1)));
    assign w_issue    = (r_state == S_ISSUE) && ~|in_full && !reset;
    assign w_load     = (r_state == S_IDLE) && !tri_clear && tri_we && !w_tri_full;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!ray_empty && (r_tri_count != '0)) begin
                    w_pop       = 1'b1;
                    w_idx_nxt   = '0;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_issue) begin
                    if (!w_last) begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end else if (!ray_empty) begin
                        w_pop     = 1'b1;
                        w_idx_nxt = '0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_tri_count <= '0;
            r_origin    <= '0;
            r_dir       <= '0;
            r_norm_hold <= '0;
            r_v0_hold   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            if (w_pop) begin
                r_origin <= ray_origin;
                r_dir    <= ray_dir;
            end
            // Snapshot the presented triangle so outputs hold once IDLE.
            if (r_state == S_ISSUE) begin
                r_norm_hold <= r_tab_norm[r_idx];
                r_v0_hold   <= r_tab_v0[r_idx];
            end
            if (r_state == S_IDLE) begin
                if (tri_clear) begin
                    r_tri_count <= '0;
                end else if (tri_we && !w_tri_full) begin
                    r_tri_count <= r_tri_count + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && w_load) begin
            r_tab_norm[r_tri_count[IDX_W-1:0]] <= tri_normal_in;
            r_tab_v0[r_tri_count[IDX_W-1:0]]   <= tri_v0_in;
        end
    end

    assign ray_rd_en  = w_pop && !reset;
    assign in_wr_en   = {4{w_issue}};
    assign busy       = (r_state != S_IDLE);
    assign tri_full   = w_tri_full;
    assign origin     = r_origin;
    assign dir        = r_dir;
    assign tri_normal = (r_state == S_ISSUE) ? r_tab_norm[r_idx] : r_norm_hold;
    assign v0         = (r_state == S_ISSUE) ? r_tab_v0[r_idx]   : r_v0_hold;
    assign tri_idx    = r_idx;
    assign ray_last   = (r_state == S_ISSUE) && w_last;

`ifdef P_HIT_FEEDER_STATS_EN
    logic [31:0] r_issue_count;
    logic [31:0] r_stall_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_issue_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_issue && (r_issue_count != '1)) begin
                r_issue_count <= r_issue_count + 32'd1;
            end
            if ((r_state == S_ISSUE) && |in_full && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    assign issue_count = r_issue_count;
    assign stall_count = r_stall_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_p_hit_feeder.sv
// ============================================================================
// Module   : tb_p_hit_feeder
// Brief    : Directed, scoreboard-based bench for p_hit_feeder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_p_hit_feeder;

    localparam int D_BITS = 32;
    localparam int N_TRI  = 8;
    localparam int IDX_W  = 3;
    localparam int W3     = 3 * D_BITS;

    logic              clock = 1'b0;
    logic              reset;
    logic              tri_we;
    logic              tri_clear;
    logic [W3-1:0]     tri_normal_in;
    logic [W3-1:0]     tri_v0_in;
    logic              tri_full;
    logic              busy;
    logic              ray_empty;
    logic              ray_rd_en;
    logic [W3-1:0]     ray_origin;
    logic [W3-1:0]     ray_dir;
    logic [3:0]        in_full;
    logic [3:0]        in_wr_en;
    logic [W3-1:0]     tri_normal;
    logic [W3-1:0]     v0;
    logic [W3-1:0]     origin;
    logic [W3-1:0]     dir;
    logic [IDX_W-1:0]  tri_idx;
    logic              ray_last;
`ifdef P_HIT_FEEDER_STATS_EN
    logic [31:0]       issue_count;
    logic [31:0]       stall_count;
`endif

    p_hit_feeder #(.D_BITS(D_BITS), .Q_BITS(16), .N_TRI(N_TRI)) dut (
        .clock         (clock),
        .reset         (reset),
        .tri_we        (tri_we),
        .tri_clear     (tri_clear),
        .tri_normal_in (tri_normal_in),
        .tri_v0_in     (tri_v0_in),
        .tri_full      (tri_full),
        .busy          (busy),
        .ray_empty     (ray_empty),
        .ray_rd_en     (ray_rd_en),
        .ray_origin    (ray_origin),
        .ray_dir       (ray_dir),
        .in_full       (in_full),
        .in_wr_en      (in_wr_en),
        .tri_normal    (tri_normal),
        .v0            (v0),
        .origin        (origin),
        .dir           (dir),
        .tri_idx       (tri_idx),
        .ray_last      (ray_last)
`ifdef P_HIT_FEEDER_STATS_EN
        ,
        .issue_count   (issue_count),
        .stall_count   (stall_count)
`endif
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [W3-1:0]    org;
        logic [W3-1:0]    dr;
        logic [W3-1:0]    nrm;
        logic [W3-1:0]    vtx;
        logic [IDX_W-1:0] idx;
        logic             last;
    } tup_t;

    tup_t          exp_q [$];
    logic [W3-1:0] rq_org [$];
    logic [W3-1:0] rq_dir [$];
    logic [W3-1:0] m_nrm [$];
    logic [W3-1:0] m_v0 [$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_no  = 0;
    int n_wr    = 0;
    int n_rd    = 0;
    int n_stall = 0;
    int tot_exp = 0;
    int first_wr = -1;
    int last_wr  = -1;
    int t0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, expv);
        end
    endtask

    task automatic fifo_drive();
        ray_empty  = (rq_org.size() == 0);
        ray_origin = ray_empty ? '0 : rq_org[0];
        ray_dir    = ray_empty ? '0 : rq_dir[0];
    endtask

    task automatic clr_stats();
        n_wr = 0; n_rd = 0; n_stall = 0; first_wr = -1; last_wr = -1;
    endtask

    // One clock: check at negedge, model FIFO pops, re-drive after the edge.
    task automatic cyc();
        tup_t e;
        @(negedge clock);
        cyc_no++;
        if (busy === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("busy_without_pending_tuple", busy, 1'b0);
            end else begin
                e = exp_q[0];
                chk("tri_idx", tri_idx, e.idx);
                chk("ray_last", ray_last, e.last);
                chk("origin", origin, e.org);
                chk("dir", dir, e.dr);
                chk("tri_normal", tri_normal, e.nrm);
                chk("v0", v0, e.vtx);
            end
        end
        if (in_full != 4'h0) begin
            chk("wr_while_full", in_wr_en, 4'h0);
            if (busy === 1'b1) n_stall++;
        end
        if (in_wr_en != 4'h0) begin
            chk("wr_en_all_bits", in_wr_en, 4'hF);
            n_wr++;
            if (first_wr < 0) first_wr = cyc_no;
            last_wr = cyc_no;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            else chk("unexpected_write", in_wr_en, 4'h0);
        end
        if (ray_rd_en === 1'b1) begin
            n_rd++;
            chk("pop_from_empty_fifo", ray_empty, 1'b0);
            if (rq_org.size() > 0) begin
                for (int t = 0; t < m_nrm.size(); t++) begin
                    e.org  = rq_org[0];
                    e.dr   = rq_dir[0];
                    e.nrm  = m_nrm[t];
                    e.vtx  = m_v0[t];
                    e.idx  = IDX_W'(t);
                    e.last = (t == m_nrm.size() - 1);
                    exp_q.push_back(e);
                end
                tot_exp += m_nrm.size();
                void'(rq_org.pop_front());
                void'(rq_dir.pop_front());
            end
        end
        @(posedge clock);
        #1;
        fifo_drive();
    endtask

    task automatic load_tri(input logic [W3-1:0] n, input logic [W3-1:0] v);
        tri_we = 1'b1;
        tri_normal_in = n;
        tri_v0_in = v;
        if (busy === 1'b0 && m_nrm.size() < N_TRI) begin
            m_nrm.push_back(n);
            m_v0.push_back(v);
        end
        cyc();
        tri_we = 1'b0;
    endtask

    task automatic clear_tris();
        tri_clear = 1'b1;
        if (busy === 1'b0) begin
            m_nrm.delete();
            m_v0.delete();
        end
        cyc();
        tri_clear = 1'b0;
    endtask

    task automatic push_ray(input logic [W3-1:0] o, input logic [W3-1:0] d);
        rq_org.push_back(o);
        rq_dir.push_back(d);
        fifo_drive();
    endtask

    task automatic run_idle(input int max_cyc, input string tag);
        int k = 0;
        while ((busy === 1'b1 || exp_q.size() != 0 ||
                (rq_org.size() != 0 && m_nrm.size() != 0)) && k < max_cyc) begin
            cyc();
            k++;
        end
        chk({tag, "_timeout"}, k < max_cyc, 1'b1);
    endtask

    initial begin
        reset = 1'b1; tri_we = 1'b0; tri_clear = 1'b0;
        tri_normal_in = '0; tri_v0_in = '0; in_full = 4'h0;
        fifo_drive();
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clock);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wr_en", in_wr_en, 4'h0);
        chk("rst_rd_en", ray_rd_en, 1'b0);
        chk("rst_tri_full", tri_full, 1'b0);
        chk("rst_origin", origin, '0);
        chk("rst_dir", dir, '0);
        @(posedge clock);
        #1;

        // 1: three triangles, one ray, no stall
        load_tri({32'h0, 32'h0, 32'h0001_0000}, {32'h0, 32'h0, 32'h0005_0000});
        load_tri({32'h0, 32'h0001_0000, 32'h0}, {32'h0002_0000, 32'h0, 32'h0});
        load_tri({32'h0001_0000, 32'h0, 32'h0}, {32'h0, 32'h0003_0000, 32'h0});
        clr_stats();
        t0 = cyc_no + 1;
        push_ray({32'h1, 32'h2, 32'h3}, {32'h0, 32'h0, 32'hFFFF_0000});
        run_idle(20, "t1");
        chk("t1_writes", n_wr, 3);
        chk("t1_pops", n_rd, 1);
        chk("t1_latency", first_wr - t0, 1);
        chk("t1_consecutive", last_wr - first_wr, 2);
        chk("t1_idle_after", busy, 1'b0);

        // 2: two triangles, four rays back-to-back
        clear_tris();
        load_tri({32'hA, 32'hB, 32'hC}, {32'h10, 32'h11, 32'h12});
        load_tri({32'hD, 32'hE, 32'hF}, {32'h20, 32'h21, 32'h22});
        clr_stats();
        for (int r = 0; r < 4; r++) push_ray({32'h100 + r, 32'h0, 32'h0}, {32'h0, 32'h200 + r, 32'h0});
        run_idle(30, "t2");
        chk("t2_writes", n_wr, 8);
        chk("t2_pops", n_rd, 4);
        chk("t2_no_bubble", last_wr - first_wr, 7);

        // 3: stall for 5 cycles at idx 1
        clear_tris();
        load_tri({32'h1, 32'h1, 32'h1}, {32'h2, 32'h2, 32'h2});
        load_tri({32'h3, 32'h3, 32'h3}, {32'h4, 32'h4, 32'h4});
        load_tri({32'h5, 32'h5, 32'h5}, {32'h6, 32'h6, 32'h6});
        clr_stats();
        push_ray({32'hAA, 32'hBB, 32'hCC}, {32'hDD, 32'hEE, 32'hFF});
        cyc();
        cyc();
        chk("t3_at_idx1", tri_idx, 3'd1);
        in_full = 4'b0100;
        repeat (5) cyc();
        in_full = 4'h0;
        run_idle(20, "t3");
        chk("t3_stall_cycles", n_stall, 5);
        chk("t3_writes", n_wr, 3);
        chk("t3_span", last_wr - first_wr, 7);
`ifdef P_HIT_FEEDER_STATS_EN
        chk("t3_stall_count", stall_count, 32'd5);
        chk("t3_issue_count", issue_count, 32'(tot_exp));
`endif

        // 4: rays with empty table stay queued; tri_we while busy ignored
        clear_tris();
        clr_stats();
        push_ray({32'h7, 32'h7, 32'h7}, {32'h8, 32'h8, 32'h8});
        push_ray({32'h9, 32'h9, 32'h9}, {32'h6, 32'h6, 32'h6});
        repeat (5) cyc();
        chk("t4_no_pop", n_rd, 0);
        chk("t4_not_busy", busy, 1'b0);
        load_tri({32'h11, 32'h12, 32'h13}, {32'h14, 32'h15, 32'h16});
        cyc();
        chk("t4_busy", busy, 1'b1);
        load_tri({32'hBAD, 32'hBAD, 32'hBAD}, {32'hBAD, 32'hBAD, 32'hBAD});
        run_idle(20, "t4a");
        clr_stats();
        push_ray({32'h31, 32'h32, 32'h33}, {32'h34, 32'h35, 32'h36});
        run_idle(20, "t4b");
        chk("t4_count_unchanged", n_wr, 1);

        // 5: overfill the table, then clear beats write
        clear_tris();
        for (int i = 0; i < N_TRI + 1; i++) begin
            load_tri({32'h1000 + i, 32'h0, 32'h1}, {32'h2000 + i, 32'h3, 32'h0});
            if (i == N_TRI - 2) chk("t5_not_full", tri_full, 1'b0);
        end
        chk("t5_full", tri_full, 1'b1);
        clr_stats();
        push_ray({32'h41, 32'h42, 32'h43}, {32'h44, 32'h45, 32'h46});
        run_idle(30, "t5a");
        chk("t5_writes", n_wr, N_TRI);
        tri_clear = 1'b1;
        tri_we = 1'b1;
        m_nrm.delete();
        m_v0.delete();
        cyc();
        tri_clear = 1'b0;
        tri_we = 1'b0;
        chk("t5_cleared", tri_full, 1'b0);
        clr_stats();
        push_ray({32'h51, 32'h52, 32'h53}, {32'h54, 32'h55, 32'h56});
        repeat (4) cyc();
        chk("t5_no_pop", n_rd, 0);
        load_tri({32'h61, 32'h62, 32'h63}, {32'h64, 32'h65, 32'h66});
        run_idle(20, "t5b");
        chk("t5_drain", n_wr, 1);

        // 6: reset mid-ray at idx 1
        clear_tris();
        load_tri({32'h71, 32'h0, 32'h0}, {32'h72, 32'h0, 32'h0});
        load_tri({32'h73, 32'h0, 32'h0}, {32'h74, 32'h0, 32'h0});
        load_tri({32'h75, 32'h0, 32'h0}, {32'h76, 32'h0, 32'h0});
        push_ray({32'h81, 32'h82, 32'h83}, {32'h84, 32'h85, 32'h86});
        cyc();
        cyc();
        chk("t6_at_idx1", tri_idx, 3'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        exp_q.delete();
        m_nrm.delete();
        m_v0.delete();
        @(negedge clock);
        chk("t6_busy", busy, 1'b0);
        chk("t6_wr_en", in_wr_en, 4'h0);
        chk("t6_tri_full", tri_full, 1'b0);
        chk("t6_origin", origin, '0);
`ifdef P_HIT_FEEDER_STATS_EN
        chk("t6_issue_count", issue_count, 32'd0);
`endif
        @(posedge clock);
        #1;
        clr_stats();
        push_ray({32'h91, 32'h92, 32'h93}, {32'h94, 32'h95, 32'h96});
        repeat (4) cyc();
        chk("t6_count_zero_no_pop", n_rd, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
